sram_like_ram_slave: RTL and testbench
======================================

Name: sram_like_ram_slave

Overview:
- Responder end of the sram_like data-port protocol.
- Accepts requests from the CPU-side sram_like initiator: req/wr/size/addr/wdata in, addr_ok/data_ok/rdata out.
- Serves each request from a single-port synchronous SRAM with byte write enables and a fixed, parameterised response latency.
- Used as a stand-alone data memory for bring-up and as a protocol-accurate model of the bus slave for CPU-side verification.

Parameters:
- ADDR_W, 14, word-address width of the RAM (RAM holds 2^ADDR_W 32-bit words).
- LATENCY, 3, cycles from address handshake (cycle A) to the data_ok cycle; legal range 3..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  1  request valid
- wr  in  1  1 = write, 0 = read
- size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- addr  in  32  byte address
- wdata  in  32  write data, already in byte-lane position
- rdata  out  32  read word, valid when data_ok = 1
- addr_ok  out  1  address handshake, combinational
- data_ok  out  1  response strobe, one cycle per transaction
- ram_en  out  1  RAM access enable, registered
- ram_wen  out  4  RAM byte write enables, registered
- ram_addr  out  ADDR_W  RAM word address, registered
- ram_wdata  out  32  RAM write data, registered
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en

Behaviour:
- Reset (rst = 1 at a clk edge):
  - state = IDLE, counter = 0.
  - ram_en = 0, ram_wen = 0, ram_addr = 0, ram_wdata = 0.
  - rdata register = 0, data_ok = 0.
  - addr_ok = 0 while rst is high.
- Reset mid-operation aborts the transaction; no data_ok is produced for it.
  - A write is performed only if its ACCESS cycle completed before reset.
- One outstanding transaction at a time.
- States and transitions:
  - IDLE: addr_ok = req. If req = 1, the handshake completes in this cycle (cycle A): latch wr, byte enables, ram word address = addr[ADDR_W+1:2], and wdata. Go to ACCESS.
  - ACCESS (A+1): ram_en = 1. ram_wen = latched enables if wr, else 0000. ram_addr and ram_wdata = latched values. Go to WAIT and load counter = LATENCY-3.
  - WAIT (A+2 .. A+LATENCY-1):
    - In the first WAIT cycle, capture ram_rdata into the rdata register, reads only.
    - Decrement the counter each cycle; when counter = 0, go to RESP.
    - ram_en = 0 throughout.
  - RESP (A+LATENCY): data_ok = 1. rdata = captured word on reads; rdata is unchanged on writes.
    - addr_ok = req in this cycle: back-to-back acceptance is allowed.
    - If req = 1, latch the new request and go to ACCESS; otherwise go to IDLE.
- addr_ok = 0 in ACCESS and WAIT regardless of req. A req that is held stays pending; a req that is dropped before addr_ok is discarded with no side effects.
- Byte enables:
  - size 00 → 0001 << addr[1:0].
  - size 01 → addr[1] ? 1100 : 0011; addr[0] is ignored.
  - size 10/11 → 1111; addr[1:0] are ignored.
- wdata is written unshifted. rdata is the full 32-bit RAM word, unshifted; lane extraction belongs to the initiator.
- addr bits above ADDR_W+1 are ignored, so addresses alias modulo the RAM size.
- rdata holds its value until the next read's capture. data_ok is never asserted in two consecutive cycles.
- Reads after a write to the same word return the written data: that write's ACCESS always precedes the read's ACCESS.

Test Plan:
- Word write/read: write addr 0x0000_0010, wdata 0xDEADBEEF, size 10 → addr_ok at A, ram_en/ram_wen = 1111/ram_addr = 4 at A+1, data_ok at A+3. A following read of the same address → rdata = 0xDEADBEEF with data_ok 3 cycles after its addr_ok.
- Byte/half lanes:
  - sb addr 0x13, wdata 0x11000000 → ram_wen = 1000.
  - sh addr 0x12, wdata 0x22330000 → ram_wen = 1100.
  - Read of 0x10 → 0x2233BEEF after the word test.
- Back-to-back: req held high over 3 reads → accepted at A, A+3, A+6; data_ok at A+3, A+6, A+9; addr_ok low in all ACCESS/WAIT cycles.
- LATENCY = 5: data_ok exactly 5 cycles after addr_ok; rdata is stable from capture through data_ok.
- Reset mid-operation:
  - rst in the cycle after accepting a write (before ACCESS) → no ram_en, no data_ok; a subsequent read shows the old data.
  - rst in WAIT → state IDLE, rdata = 0.
- Request withdrawn: req high for 1 cycle during WAIT, then low → that request is never accepted; only the in-flight data_ok occurs.

Source files
------------

// File: rtl/sram_like_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_ram_slave
// Purpose  : Responder end of the sram_like data-port protocol. Accepts one
//            request at a time from the CPU-side initiator and serves it from
//            a single-port synchronous SRAM with byte write enables. Every
//            transaction returns data_ok exactly LATENCY cycles after its
//            address handshake.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock
//   rst        in   synchronous, active-high reset
//   req        in   request valid
//   wr         in   1 = write, 0 = read
//   size       in   00 byte, 01 half, 10/11 word
//   addr       in   byte address (bits above ADDR_W+1 ignored -> aliasing)
//   wdata      in   write data, already in byte-lane position
//   rdata      out  full 32-bit RAM word, valid with data_ok
//   addr_ok    out  address handshake (combinational)
//   data_ok    out  one-cycle response strobe
//   ram_en     out  RAM access enable
//   ram_wen    out  RAM byte write enables
//   ram_addr   out  RAM word address
//   ram_wdata  out  RAM write data
//   ram_rdata  in   RAM read data, valid the cycle after ram_en
// ============================================================================
module sram_like_ram_slave #(
  parameter int ADDR_W  = 14,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  // WAIT lasts LATENCY-2 cycles; the counter runs down from LATENCY-3 to 0.
  localparam logic [3:0] C_WAIT_CNT = 4'(LATENCY - 3);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                first_q, first_d;
  logic                wr_q, wr_d;
  logic                ram_en_q, ram_en_d;
  logic [3:0]          ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [31:0]         ram_wdata_q, ram_wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [3:0]          be_w;
  logic                addr_ok_w;
  logic                data_ok_w;

  // High address bits are intentionally dropped: addresses alias modulo RAM size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  always_comb begin
    be_w = 4'b1111;
    case (size)
      2'b00:   be_w = 4'b0001 << addr[1:0];
      2'b01:   be_w = addr[1] ? 4'b1100 : 4'b0011;
      default: be_w = 4'b1111;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    wr_d        = wr_q;
    ram_en_d    = 1'b0;
    ram_wen_d   = 4'b0000;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    addr_ok_w   = 1'b0;
    data_ok_w   = 1'b0;

    case (state_q)
      S_IDLE: begin
        addr_ok_w = req;
      end
      S_ACCESS: begin
        state_d = S_WAIT;
        cnt_d   = C_WAIT_CNT;
        first_d = 1'b1;
      end
      S_WAIT: begin
        first_d = 1'b0;
        // RAM data for the ACCESS cycle is only valid in the first WAIT cycle.
        if (first_q && !wr_q) begin
          rdata_d = ram_rdata;
        end
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        data_ok_w = 1'b1;
        addr_ok_w = req;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake (from IDLE or back-to-back from RESP): the RAM command
    // registers are loaded directly so they present in the ACCESS cycle.
    if (addr_ok_w) begin
      state_d     = S_ACCESS;
      wr_d        = wr;
      ram_en_d    = 1'b1;
      ram_wen_d   = wr ? be_w : 4'b0000;
      ram_addr_d  = addr[ADDR_W+1:2];
      ram_wdata_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      first_q     <= 1'b0;
      wr_q        <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_wen_q   <= 4'b0000;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      wr_q        <= wr_d;
      ram_en_q    <= ram_en_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Reset asserted during ACCESS must keep the RAM from committing the
  // aborted access, so the command strobes are masked while rst is high.
  assign ram_en    = ram_en_q & ~rst;
  assign ram_wen   = rst ? 4'b0000 : ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rdata     = rdata_q;
  assign addr_ok   = addr_ok_w & ~rst;
  assign data_ok   = data_ok_w & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_sram_like_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_ram_slave
// Purpose  : Self-checking bench. Two responders (LATENCY 3 and 5), each with
//            its own SRAM model, are checked against a word-array reference
//            memory and the protocol timing rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_like_ram_slave;

  localparam int TB_AW = 8;
  localparam int NW    = 256;

  logic              clk;
  logic              rst       [2];
  logic              req       [2];
  logic              wr        [2];
  logic [1:0]        size      [2];
  logic [31:0]       addr      [2];
  logic [31:0]       wdata     [2];
  logic [31:0]       rdata     [2];
  logic              addr_ok   [2];
  logic              data_ok   [2];
  logic              ram_en    [2];
  logic [3:0]        ram_wen   [2];
  logic [TB_AW-1:0]  ram_addr  [2];
  logic [31:0]       ram_wdata [2];
  logic [31:0]       ram_rdata [2];

  logic [31:0] mem     [2][NW];
  logic [31:0] ref_mem [2][NW];

  int n_checks = 0;
  int n_err    = 0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      sram_like_ram_slave #(
        .ADDR_W  (TB_AW),
        .LATENCY ((gi == 0) ? 3 : 5)
      ) u_dut (
        .clk       (clk),
        .rst       (rst[gi]),
        .req       (req[gi]),
        .wr        (wr[gi]),
        .size      (size[gi]),
        .addr      (addr[gi]),
        .wdata     (wdata[gi]),
        .rdata     (rdata[gi]),
        .addr_ok   (addr_ok[gi]),
        .data_ok   (data_ok[gi]),
        .ram_en    (ram_en[gi]),
        .ram_wen   (ram_wen[gi]),
        .ram_addr  (ram_addr[gi]),
        .ram_wdata (ram_wdata[gi]),
        .ram_rdata (ram_rdata[gi])
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous SRAM stand-in: byte-masked write, read data one cycle later.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_en[d] === 1'b1) begin
        logic [31:0] w;
        w = mem[d][ram_addr[d]];
        for (int b = 0; b < 4; b++)
          if (ram_wen[d][b]) w[8*b +: 8] = ram_wdata[d][8*b +: 8];
        mem[d][ram_addr[d]] <= w;
        ram_rdata[d]        <= mem[d][ram_addr[d]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 3 : 5;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % NW);
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 4'(1 << (a % 4));
      2'd1:    return (((a / 2) % 2) == 1) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  // Drive a request and wait (bounded) for its handshake; returns in cycle A.
  task automatic accept(input int d, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, output bit ok);
    @(negedge clk);
    req[d] = 1'b1; wr[d] = w; size[d] = sz; addr[d] = a; wdata[d] = wd;
    ok = 1'b0;
    for (int t = 0; t < 16; t++) begin
      #1;
      if (addr_ok[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("addr_ok_wait", 32'(ok), 32'd1);
    if (!ok) req[d] = 1'b0;
  endtask

  task automatic txn(input int d, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    bit          ok;
    int          L, i;
    logic [3:0]  be;
    logic [31:0] e, prev;
    L  = lat(d);
    i  = widx(a);
    be = ref_be(sz, a);
    rd = '0;
    accept(d, w, sz, a, wd, ok);
    if (!ok) return;
    prev = rdata[d];
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[d][i][8*b +: 8] = wd[8*b +: 8];
    end
    e = ref_mem[d][i];
    @(negedge clk);
    req[d] = 1'b0;
    for (int k = 1; k <= L; k++) begin
      #1;
      chk("data_ok", 32'(data_ok[d]), 32'(k == L));
      if (k < L) chk("addr_ok_busy", 32'(addr_ok[d]), 32'd0);
      if (k == 1) begin
        chk("ram_en_access", 32'(ram_en[d]), 32'd1);
        chk("ram_wen", 32'(ram_wen[d]), w ? 32'(be) : 32'd0);
        chk("ram_addr", 32'(ram_addr[d]), 32'(i));
        if (w) chk("ram_wdata", ram_wdata[d], wd);
      end else begin
        chk("ram_en_idle", 32'(ram_en[d]), 32'd0);
      end
      if (!w && k >= 3) chk("rdata", rdata[d], e);
      if (w && k == L) chk("wr_rdata_hold", rdata[d], prev);
      if (k == L) rd = rdata[d];
      if (k < L) @(negedge clk);
    end
  endtask

  // Three reads with req held high; accepts at 0, L, 2L and responds at L, 2L, 3L.
  task automatic b2b(input int d);
    int          L;
    logic [31:0] a [3];
    logic [31:0] e [3];
    L = lat(d);
    a[0] = 32'h10; a[1] = 32'h40; a[2] = 32'h20;
    for (int j = 0; j < 3; j++) e[j] = ref_mem[d][widx(a[j])];
    @(negedge clk);
    req[d] = 1'b1; wr[d] = 1'b0; size[d] = 2'd2; addr[d] = a[0]; wdata[d] = '0;
    for (int t = 0; t <= 3*L; t++) begin
      #1;
      chk("b2b_addr_ok", 32'(addr_ok[d]), 32'((t % L == 0) && (t <= 2*L)));
      chk("b2b_data_ok", 32'(data_ok[d]), 32'((t % L == 0) && (t > 0)));
      if ((t % L == 0) && (t > 0)) chk("b2b_rdata", rdata[d], e[t/L-1]);
      if (t % L == 1) begin
        chk("b2b_ram_en", 32'(ram_en[d]), 32'd1);
        chk("b2b_ram_addr", 32'(ram_addr[d]), 32'(widx(a[t/L])));
      end
      if (t < 3*L) begin
        @(negedge clk);
        if (t % L == 0) begin
          if (t == 2*L) req[d] = 1'b0;
          else          addr[d] = a[t/L+1];
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    bit          ok;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NW; i++) begin
        mem[d][i]     = 32'd0;
        ref_mem[d][i] = 32'd0;
      end
      rst[d] = 1'b1; req[d] = 1'b1; wr[d] = 1'b1; size[d] = 2'd2;
      addr[d] = 32'h10; wdata[d] = 32'hFFFF_FFFF;
    end

    // Reset state, with a request pending that must not be acknowledged.
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_addr_ok", 32'(addr_ok[d]), 32'd0);
      chk("rst_data_ok", 32'(data_ok[d]), 32'd0);
      chk("rst_ram_en", 32'(ram_en[d]), 32'd0);
      chk("rst_ram_wen", 32'(ram_wen[d]), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr[d]), 32'd0);
      chk("rst_ram_wdata", ram_wdata[d], 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; req[d] = 1'b0;
    end

    // Word write/read, then byte and half lanes on both latencies.
    for (int d = 0; d < 2; d++) begin
      txn(d, 1'b1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, rd);
      txn(d, 1'b0, 2'b10, 32'h0000_0010, 32'h0, rd);
      chk("word_rd", rd, 32'hDEAD_BEEF);
      txn(d, 1'b1, 2'b00, 32'h0000_0013, 32'h1100_0000, rd);
      txn(d, 1'b1, 2'b01, 32'h0000_0012, 32'h2233_0000, rd);
      txn(d, 1'b0, 2'b10, 32'h0000_0010, 32'h0, rd);
      chk("lane_rd", rd, 32'h2233_BEEF);
      txn(d, 1'b1, 2'b10, 32'h0000_0020, 32'h1234_5678, rd);
      txn(d, 1'b1, 2'b10, 32'h0000_0040, 32'hCAFE_F00D, rd);
    end

    // Back-to-back acceptance with req held.
    b2b(0);
    b2b(1);

    // Reset between acceptance and ACCESS: the write must never reach RAM.
    accept(0, 1'b1, 2'b10, 32'h10, 32'h5555_5555, ok);
    if (ok) begin
      @(negedge clk);
      rst[0] = 1'b1; req[0] = 1'b0;
      #1;
      chk("abort_ram_en", 32'(ram_en[0]), 32'd0);
      chk("abort_data_ok", 32'(data_ok[0]), 32'd0);
      @(negedge clk);
      rst[0] = 1'b0;
      for (int k = 0; k < 6; k++) begin
        #1;
        chk("abort_quiet_dok", 32'(data_ok[0]), 32'd0);
        chk("abort_quiet_en", 32'(ram_en[0]), 32'd0);
        @(negedge clk);
      end
    end
    txn(0, 1'b0, 2'b10, 32'h10, 32'h0, rd);
    chk("abort_old_data", rd, 32'h2233_BEEF);

    // Reset in WAIT after the capture (LATENCY 5 instance).
    accept(1, 1'b0, 2'b10, 32'h40, 32'h0, ok);
    if (ok) begin
      @(negedge clk); req[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("wait_captured", rdata[1], 32'hCAFE_F00D);
      rst[1] = 1'b1;
      #1;
      chk("wait_rst_dok", 32'(data_ok[1]), 32'd0);
      @(negedge clk);
      rst[1] = 1'b0;
      #1;
      chk("wait_rst_rdata", rdata[1], 32'd0);
      for (int k = 0; k < 6; k++) begin
        #1;
        chk("wait_rst_quiet", 32'(data_ok[1]), 32'd0);
        @(negedge clk);
      end
    end
    txn(1, 1'b0, 2'b10, 32'h40, 32'h0, rd);
    chk("post_rst_read", rd, 32'hCAFE_F00D);

    // A request raised for one cycle during WAIT is discarded.
    accept(0, 1'b0, 2'b10, 32'h10, 32'h0, ok);
    if (ok) begin
      @(negedge clk); req[0] = 1'b0;
      @(negedge clk);
      req[0] = 1'b1; wr[0] = 1'b1; size[0] = 2'd2; addr[0] = 32'h80; wdata[0] = 32'hBADB_AD00;
      #1;
      chk("wd_addr_ok", 32'(addr_ok[0]), 32'd0);
      @(negedge clk);
      req[0] = 1'b0;
      #1;
      chk("wd_inflight_dok", 32'(data_ok[0]), 32'd1);
      chk("wd_inflight_rd", rdata[0], 32'h2233_BEEF);
      chk("wd_addr_ok_resp", 32'(addr_ok[0]), 32'd0);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        #1;
        chk("wd_quiet_dok", 32'(data_ok[0]), 32'd0);
        chk("wd_quiet_en", 32'(ram_en[0]), 32'd0);
      end
    end
    txn(0, 1'b0, 2'b10, 32'h80, 32'h0, rd);
    chk("wd_untouched", rd, 32'd0);

    // Randomized traffic with aliasing high address bits.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        txn(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, rd);
      end
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
